// File: rtl/sar_host_pkg.sv
// Shared widths, FIFO geometry and FSM state encoding for the SAR host sequencer.
package sar_host_pkg;

    localparam int unsigned SAR_DATA_W = 3;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_AW    = 2;

    typedef enum logic [2:0] {
        sIdle     = 3'd0,
        sWaitTick = 3'd1,
        sStart    = 3'd2,
        sBusy     = 3'd3,
        sCapture  = 3'd4
    } state_e;

endpackage

// File: rtl/sar_result_fifo.sv
// Four-entry show-ahead result FIFO; the head is registered so it holds its
// last value once the FIFO drains.
module sar_result_fifo
    import sar_host_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [SAR_DATA_W-1:0] wr_data,
    input  logic                  pop,
    output logic [SAR_DATA_W-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  push_ok
);

    logic [SAR_DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_n;
    logic [FIFO_AW:0]      count_q, count_d;
    logic [SAR_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                  pop_ok;

    assign empty   = (count_q == '0);
    // Depth is a power of two, so the count MSB alone marks full.
    assign full    = count_q[FIFO_AW];
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rd_data = rd_data_q;

    always_comb begin
        rd_ptr_n  = rd_ptr_q + {{(FIFO_AW-1){1'b0}}, pop_ok};
        count_d   = count_q + {{FIFO_AW{1'b0}}, push_ok} - {{FIFO_AW{1'b0}}, pop_ok};
        rd_data_d = rd_data_q;
        if (count_d != '0) begin
            // New head is the incoming word when it lands straight at the read pointer.
            if (push_ok && (rd_ptr_n == wr_ptr_q)) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem_q[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q  <= rd_ptr_n;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/sar_conv_host.sv
// Host sequencer for the SAR controller: periodic start requests, handshake
// tracking with a per-phase watchdog, and result capture into a FIFO.
module sar_conv_host
    import sar_host_pkg::*;
#(
    parameter int unsigned PERIOD  = 32,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clearErr,
    input  logic                  nEndCnv,
    input  logic [SAR_DATA_W-1:0] dataIn,
    output logic                  nStartCnv,
    input  logic                  rdEn,
    output logic [SAR_DATA_W-1:0] rdData,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  timeoutErr,
    output logic [7:0]            convCount,
    output logic [2:0]            stateOut
);

    localparam logic [7:0] TickLast = 8'(PERIOD - 1);
    localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] tick_q, tick_d;
    logic       tick;
    logic       pend_q, pend_d, pend_clr;
    logic [7:0] wdog_q, wdog_d;
    logic       nstart_q, nstart_d;
    logic       nend_prev_q;
    logic [7:0] conv_cnt_q, conv_cnt_d;
    logic       ovf_q, ovf_d;
    logic       tmo_q, tmo_d, tmo_set;
    logic       push, push_ok;

    always_comb begin
        tick   = enable && (tick_q == TickLast);
        tick_d = (enable && !tick) ? tick_q + 8'd1 : 8'd0;
    end

    always_comb begin
        state_d  = state_q;
        nstart_d = nstart_q;
        wdog_d   = wdog_q;
        pend_clr = 1'b0;
        tmo_set  = 1'b0;
        push     = 1'b0;
        unique case (state_q)
            sIdle: begin
                nstart_d = 1'b1;
                if (enable) begin
                    state_d = sWaitTick;
                end
            end
            sWaitTick: begin
                if (!enable) begin
                    pend_clr = 1'b1;
                    state_d  = sIdle;
                end else if (pend_q) begin
                    pend_clr = 1'b1;
                    nstart_d = 1'b0;
                    wdog_d   = '0;
                    state_d  = sStart;
                end
            end
            sStart: begin
                wdog_d = wdog_q + 8'd1;
                if (nEndCnv) begin
                    // Release the request before the controller can rearm.
                    nstart_d = 1'b1;
                    wdog_d   = '0;
                    state_d  = sBusy;
                end else if (wdog_q == WdogLast) begin
                    tmo_set  = 1'b1;
                    nstart_d = 1'b1;
                    state_d  = sWaitTick;
                end
            end
            sBusy: begin
                wdog_d = wdog_q + 8'd1;
                if (nend_prev_q && !nEndCnv) begin
                    state_d = sCapture;
                end else if (wdog_q == WdogLast) begin
                    tmo_set = 1'b1;
                    state_d = sWaitTick;
                end
            end
            sCapture: begin
                push    = 1'b1;
                state_d = sWaitTick;
            end
            default: begin
                nstart_d = 1'b1;
                state_d  = sIdle;
            end
        endcase
    end

    // Set events take priority over a coincident clear.
    always_comb begin
        pend_d     = tick | (pend_q & ~pend_clr);
        conv_cnt_d = push ? conv_cnt_q + 8'd1 : conv_cnt_q;
        ovf_d      = (push & ~push_ok) | (ovf_q & ~clearErr);
        tmo_d      = tmo_set | (tmo_q & ~clearErr);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= sIdle;
            tick_q      <= '0;
            pend_q      <= 1'b0;
            wdog_q      <= '0;
            nstart_q    <= 1'b1;
            nend_prev_q <= 1'b0;
            conv_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            pend_q      <= pend_d;
            wdog_q      <= wdog_d;
            nstart_q    <= nstart_d;
            nend_prev_q <= nEndCnv;
            conv_cnt_q  <= conv_cnt_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
        end
    end

    sar_result_fifo u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (dataIn),
        .pop     (rdEn),
        .rd_data (rdData),
        .empty   (empty),
        .full    (full),
        .push_ok (push_ok)
    );

    assign nStartCnv  = nstart_q;
    assign overflow   = ovf_q;
    assign timeoutErr = tmo_q;
    assign convCount  = conv_cnt_q;
    assign stateOut   = state_q;

endmodule
